// File: rtl/spi_slave.sv
// SPI slave endpoint oversampled in the clk domain: 8-bit MSB-first frames, all CPOL/CPHA modes,
// one-entry tx buffer with valid/ready, received bytes strobed out on rx_valid.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       cpol,
  input  logic       cpha,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_prev;
  logic                    cs_prev;
  logic                    cpol_q;
  logic                    cpha_q;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_W-1:0]       tx_shift;
  logic [DATA_W-2:0]       rx_shift;
  logic [DATA_W-1:0]       buf_data;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_edge, cs_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, tx_write, load;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge classification relative to the mode latched at chip-select fall
  assign sclk_edge   = sclk_s ^ sclk_prev;
  assign cs_fall     = cs_prev & ~cs_s;
  assign lead_edge   = sclk_edge & (sclk_prev == cpol_q);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  // tx_ready doubles as the buffer-empty flag
  assign tx_write = tx_valid & tx_ready;
  assign load     = ((state == IDLE) & cs_fall) |
                    ((state == ACTIVE) & ~cs_s & sample_edge & (bit_cnt == CNT_W'(DATA_W - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sclk_sync   <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      sclk_prev   <= 1'b0;
      cs_prev     <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      buf_data    <= '0;
      miso        <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev   <= sclk_s;
      cs_prev     <= cs_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            bit_cnt <= '0;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
          end
        end
        ACTIVE: begin
          miso <= tx_shift[DATA_W-1];
          // Deasserted chip select wins over any coincident sclk edge
          if (cs_s) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data  <= {rx_shift, mosi_s};
              rx_valid <= 1'b1;
            end
          end else if (shift_edge && (bit_cnt != '0)) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Buffer load/write; a write alongside an empty-buffer load still fills the buffer
      if (load) begin
        if (!tx_ready) begin
          tx_shift <= buf_data;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
        tx_ready <= ~tx_write;
        if (tx_write) buf_data <= tx_data;
      end else if (tx_write) begin
        buf_data <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Clocked SPI slave endpoint: the downstream peer of the SPI master on the same bus. It receives MOSI bytes and returns MISO bytes for one chip select. SCLK, CS and MOSI are oversampled in the system clock domain, so no logic runs on SCLK. Received bytes are presented as one-cycle strobes, and transmit bytes come from a one-entry buffer with a valid/ready handshake. Supports all four CPOL/CPHA modes, MSB first, 8-bit frames, with back-to-back bytes inside one CS assertion.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for sclk, cs_n and mosi; legal values 2..3.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; it is released synchronously by the environment.
- sclk  in  1  SPI clock from the master; asynchronous to clk.
- cs_n  in  1  chip select for this slave, active-low (the master's cs0/cs1/cs2).
- mosi  in  1  serial data from the master.
- cpol  in  1  clock idle level.
- cpha  in  1  0 = sample on the leading edge; 1 = sample on the trailing edge.
- miso  out  1  serial data to the master.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  the tx buffer is empty; a write occurs on clk when tx_valid && tx_ready.
- rx_data  out  8  last complete received byte; held until the next byte completes.
- rx_valid  out  1  one-cycle strobe; rx_data was updated this cycle.
- tx_underrun  out  1  one-cycle strobe; a load found the tx buffer empty.
- busy  out  1  the FSM is in ACTIVE.

## Operation
- Synchronizers:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - One further flop per signal holds its previous synced value, and edges are detected from synced vs previous.
  - Synchronizers reset to sclk=0, cs_n=1, mosi=0.
- Mode register:
  - cpol and cpha are latched at the detected cs_n fall.
  - Changes while busy have no effect.
- Edge naming:
  - Leading edge = synced sclk leaves the latched cpol level.
  - Trailing edge = synced sclk returns to it.
  - Sample edge = leading if cpha=0, else trailing. Shift edge = the other one.
- FSM, IDLE -> ACTIVE on a detected cs_n fall:
  - bit_cnt <= 0.
  - tx_shift <= the tx buffer contents if the buffer is full, else 8'h00 with a tx_underrun pulse.
  - The buffer becomes empty.
- FSM, ACTIVE -> IDLE on a detected cs_n rise, or when synced cs_n is 1:
  - The partial rx byte is discarded, with no rx_valid.
  - bit_cnt <= 0 and tx_shift is discarded.
  - The tx buffer is unaffected.
- In IDLE, sclk edges are ignored.
- Sample edge (ACTIVE):
  - rx_shift <= {rx_shift[6:0], mosi_synced}.
  - bit_cnt <= bit_cnt+1, wrapping 7 -> 0.
  - On the wrap: rx_data <= the completed byte, rx_valid=1, and tx_shift reloads from the buffer using the same rule as CS fall, including underrun.
- Shift edge (ACTIVE): if bit_cnt != 0, tx_shift <= tx_shift << 1. If bit_cnt == 0 there is no shift, so the freshly loaded MSB stays presented.
- miso:
  - miso = registered tx_shift[7] while ACTIVE.
  - miso = 0 in IDLE.
- tx buffer: a write and a load in the same cycle with the buffer empty gives an underrun for the load, and the buffer ends full with the new byte.
- Simultaneous edges:
  - A cs_n rise detected in the same cycle as a sample edge: the cs_n rise wins, and no rx_valid is issued.
  - A cs_n fall together with an sclk edge: the sclk edge is ignored.

## Timing
- Reset values: miso=0, tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0, FSM=IDLE, bit_cnt=0, tx_shift=0, rx_shift=0.
- Pin-to-action latency is SYNC_STAGES+1 clk edges (3 at default).
  - rx_valid rises 3 clk after the 8th sample edge at the pin.
  - miso is valid 4 clk after the cs_n fall, or after the shift edge, at the pin.
- Bus requirements:
  - SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods.
  - CS-to-first-edge and last-edge-to-CS-rise ≥ the same.
  - Consecutive CS assertions separated by ≥ 2 clk periods.
- tx_ready drops the cycle after the accepted write and rises the cycle after a load.
- rx_valid and tx_underrun are exactly one cycle wide.
- Asserting reset mid-frame forces all outputs to their reset values at once. After release, the slave waits for a fresh cs_n fall.

## Test plan
- Mode 0:
  - Stimulus: buffer 8'hA5; master sends 8'h3C with 8-clk SCLK half-periods.
  - Required: rx_data=8'h3C with a single rx_valid; MISO bits at the master = 1,0,1,0,0,1,0,1; busy falls after CS rise.
- All four modes: exchange 8'h81 / 8'h7E with correct MSB-first alignment; cpol changed mid-frame has no effect.
- Back-to-back:
  - Stimulus: 3 bytes 8'h01, 8'h02, 8'h03 under one CS; tx written 8'h10, 8'h20, 8'h30 on each tx_ready.
  - Required: three rx_valid pulses in order; master receives 8'h10, 8'h20, 8'h30.
- Underrun: buffer empty at CS fall; master receives 8'h00, tx_underrun pulses once, and rx is still correct.
- Abort: CS rises after 5 bits of 8'hFF. Required: no rx_valid, rx_data unchanged. The next full frame of 8'h55 is received correctly.
- Reset mid-frame after 4 bits: outputs go to reset values immediately, and the next frame of 8'hC3 is received correctly.
